// File: rtl/pet_pkg.sv
// Shared definitions for the PET .PRG DMA loader.
//   prg_state_t          : loader state encoding
//   PET_RAM_TOP_DEFAULT  : highest DMA-reachable RAM address
//   PET_ZP_VARTAB        : zero-page address of the first BASIC end pointer
//   PET_FIXUP_BYTES      : number of pointer bytes patched after a load
// Optional feature macro: PET_PRG_PTR_FIXUP_EN (adds the FIX state).
package pet_pkg;

  localparam logic [15:0] PET_RAM_TOP_DEFAULT = 16'h7FFF;
  localparam logic [7:0]  PET_ZP_VARTAB       = 8'h2A;
  localparam int          PET_FIXUP_BYTES     = 6;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_LO = 3'd1,
    HDR_HI = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
`ifdef PET_PRG_PTR_FIXUP_EN
    FIX    = 3'd5,
`endif
    DONE   = 3'd6,
    ERR    = 3'd7
  } prg_state_t;

  // A load is in progress in every state except the idle/terminal ones.
  function automatic logic is_active(input prg_state_t s);
    case (s)
      HDR_LO, HDR_HI, DATA, WRITE: is_active = 1'b1;
`ifdef PET_PRG_PTR_FIXUP_EN
      FIX:                         is_active = 1'b1;
`endif
      default:                     is_active = 1'b0;
    endcase
  endfunction

  // States in which a host byte can be accepted.
  function automatic logic takes_bytes(input prg_state_t s);
    case (s)
      HDR_LO, HDR_HI, DATA: takes_bytes = 1'b1;
      default:              takes_bytes = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pet_dma_writer.sv
// Single-byte DMA write engine for the PET loader.
// Latches an address/data pair on start and holds dma_we for WE_CYCLES clocks
// with address and data stable. abort drops dma_we on the next clock.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   abort                  : cancel the current write
//   start, addr_in, data_in: launch a write (only while idle)
//   dma_addr, dma_dout     : registered RAM address/data
//   dma_we                 : registered RAM write enable
//   write_done             : high during the last dma_we cycle
module pet_dma_writer #(
  parameter int WE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        abort,
  input  logic        start,
  input  logic [14:0] addr_in,
  input  logic [7:0]  data_in,
  output logic [14:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_we,
  output logic        write_done
);

  localparam logic [1:0] CNT_LAST = 2'(WE_CYCLES - 1);

  logic [1:0] cnt;

  assign write_done = dma_we && (cnt == CNT_LAST);

  // Write-enable stretcher with latched address and data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dma_addr <= 15'd0;
      dma_dout <= 8'd0;
      dma_we   <= 1'b0;
      cnt      <= 2'd0;
    end else if (abort) begin
      dma_we <= 1'b0;
      cnt    <= 2'd0;
    end else if (start) begin
      dma_addr <= addr_in;
      dma_dout <= data_in;
      dma_we   <= 1'b1;
      cnt      <= 2'd0;
    end else if (dma_we) begin
      if (cnt == CNT_LAST) begin
        dma_we <= 1'b0;
        cnt    <= 2'd0;
      end else begin
        cnt <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/pet_prg_loader.sv
// PET .PRG loader: parses the 2-byte little-endian load address from the host
// stream and writes the following bytes to consecutive RAM addresses through
// the RAM's DMA port. Bytes above RAM_TOP are dropped and flag an error.
// Optional macro PET_PRG_PTR_FIXUP_EN: after a clean load, writes end_addr
// into VARTAB/ARYTAB/STREND (zero page 0x2A..0x2F, low byte first).
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   load_start, load_end : host framing pulses
//   in_valid/in_data/in_ready : byte stream handshake
//   dma_addr/dma_dout/dma_we  : RAM DMA write port
//   busy, done, error    : status (done/error sticky until load_start)
//   end_addr             : first address after the last byte of the file
module pet_prg_loader
  import pet_pkg::*;
#(
  parameter int          WE_CYCLES = 1,
  parameter logic [15:0] RAM_TOP   = PET_RAM_TOP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_start,
  input  logic        load_end,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [14:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] end_addr
);

  prg_state_t  state, next_state, finish_target;
  logic [15:0] ptr, ptr_next, end_addr_next;
  logic        ovf, ovf_next;
  logic        end_pend, end_pend_next;
  logic        accept, end_req;
  logic        wr_start, write_done;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
`ifdef PET_PRG_PTR_FIXUP_EN
  logic [2:0]  fix_idx, fix_idx_next;
`endif

  assign accept  = in_valid && in_ready;
  // A load_end seen while a write was pending is remembered in end_pend.
  assign end_req = load_end || end_pend;

`ifdef PET_PRG_PTR_FIXUP_EN
  assign finish_target = ovf ? ERR : FIX;
`else
  assign finish_target = ovf ? ERR : DONE;
`endif

  // Next-state, pointer and write-launch logic.
  always_comb begin
    next_state    = state;
    ptr_next      = ptr;
    ovf_next      = ovf;
    end_pend_next = end_pend;
    end_addr_next = end_addr;
    wr_start      = 1'b0;
    wr_addr       = ptr[14:0];
    wr_data       = in_data;
`ifdef PET_PRG_PTR_FIXUP_EN
    fix_idx_next  = fix_idx;
`endif
    if (load_start) begin
      next_state    = HDR_LO;
      ptr_next      = 16'd0;
      ovf_next      = 1'b0;
      end_pend_next = 1'b0;
`ifdef PET_PRG_PTR_FIXUP_EN
      fix_idx_next  = 3'd0;
`endif
    end else begin
      case (state)
        HDR_LO: begin
          if (accept) begin
            ptr_next[7:0] = in_data;
            next_state    = end_req ? ERR : HDR_HI;
          end else if (end_req) begin
            next_state = ERR;
          end else begin
            next_state = HDR_LO;
          end
        end
        HDR_HI: begin
          if (accept) begin
            ptr_next[15:8] = in_data;
            next_state     = DATA;
            end_pend_next  = end_req;  // header completes first, end handled in DATA
          end else if (end_req) begin
            next_state = ERR;
          end else begin
            next_state = HDR_HI;
          end
        end
        DATA: begin
          if (accept) begin
            wr_start      = (ptr <= RAM_TOP);
            next_state    = (ptr <= RAM_TOP) ? WRITE : DATA;
            ovf_next      = ovf | (ptr > RAM_TOP) | (ptr == 16'hFFFF);
            ptr_next      = ptr + 16'd1;
            end_pend_next = end_req;   // byte first, then the end marker
          end else if (end_req) begin
            next_state    = finish_target;
            end_addr_next = ptr;
            end_pend_next = 1'b0;
          end else begin
            next_state = DATA;
          end
        end
        WRITE: begin
          if (write_done) begin
            if (end_req) begin
              next_state    = finish_target;
              end_addr_next = ptr;
            end else begin
              next_state = DATA;
            end
            end_pend_next = 1'b0;
          end else begin
            end_pend_next = end_req;
          end
        end
`ifdef PET_PRG_PTR_FIXUP_EN
        FIX: begin
          wr_addr = {7'd0, PET_ZP_VARTAB + {5'd0, fix_idx}};
          wr_data = fix_idx[0] ? end_addr[15:8] : end_addr[7:0];
          if (write_done) begin
            if (fix_idx == 3'(PET_FIXUP_BYTES - 1)) begin
              next_state = DONE;
            end else begin
              fix_idx_next = fix_idx + 3'd1;
            end
          end else if (!dma_we) begin
            wr_start = 1'b1;           // writer idle: launch the next pointer byte
          end else begin
            next_state = FIX;
          end
        end
`endif
        DONE:    next_state = IDLE;
        ERR:     next_state = IDLE;
        IDLE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= 16'd0;
      ovf      <= 1'b0;
      end_pend <= 1'b0;
      end_addr <= 16'd0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
`ifdef PET_PRG_PTR_FIXUP_EN
      fix_idx  <= 3'd0;
`endif
    end else begin
      state    <= next_state;
      ptr      <= ptr_next;
      ovf      <= ovf_next;
      end_pend <= end_pend_next;
      end_addr <= end_addr_next;
      in_ready <= takes_bytes(next_state);
      busy     <= is_active(next_state);
      done     <= load_start ? 1'b0 : (done  | (next_state == DONE));
      error    <= load_start ? 1'b0 : (error | (next_state == ERR));
`ifdef PET_PRG_PTR_FIXUP_EN
      fix_idx  <= fix_idx_next;
`endif
    end
  end

  pet_dma_writer #(.WE_CYCLES(WE_CYCLES)) u_writer (
    .clk        (clk),
    .reset_n    (reset_n),
    .abort      (load_start),
    .start      (wr_start),
    .addr_in    (wr_addr),
    .data_in    (wr_data),
    .dma_addr   (dma_addr),
    .dma_dout   (dma_dout),
    .dma_we     (dma_we),
    .write_done (write_done)
  );

endmodule
